uart_rx_deframer: RTL



---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_2ff.sv | 36 +++
 rtl/uart_rx_deframer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
//   uart_state_e            : receiver FSM states
//   DEFAULT_CLOCKS_PER_BAUD : 100 MHz / 115200
//   BAUD_CNT_W              : width of the baud counter
package uart_pkg;

  localparam int unsigned BAUD_CNT_W = 24;

  localparam logic [BAUD_CNT_W-1:0] DEFAULT_CLOCKS_PER_BAUD = 24'd868;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk_i : sampling clock
//   rst_i : asynchronous active-high reset, loads RESET_VAL into both flops
//   d_i   : asynchronous input
//   q_o   : synchronized output (two clocks of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver. Samples each bit at its centre using a baud counter that
// is loaded on entry to each timed state, and shifts data in LSB-first.
// Ports:
//   i_clk       : system clock
//   i_reset     : asynchronous active-high reset
//   i_uart_rx   : asynchronous serial line, idle high
//   o_wr        : one-cycle strobe, received byte valid
//   o_data      : received byte, held until the next o_wr
//   o_frame_err : stop bit sampled low; qualified by o_wr
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter logic [BAUD_CNT_W-1:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic       o_wr,
  output logic [7:0] o_data,
  output logic       o_frame_err
);

  localparam logic [BAUD_CNT_W-1:0] CntOne   = 1;
  localparam logic [BAUD_CNT_W-1:0] Half     = CLOCKS_PER_BAUD >> 1;
  localparam logic [BAUD_CNT_W-1:0] HalfLoad = Half - CntOne;
  localparam logic [BAUD_CNT_W-1:0] BaudLoad = CLOCKS_PER_BAUD - CntOne;

  logic rx_s;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i (i_clk),
    .rst_i (i_reset),
    .d_i   (i_uart_rx),
    .q_o   (rx_s)
  );

  uart_state_e           state_d, state_q;
  logic [BAUD_CNT_W-1:0] cnt_d, cnt_q;
  logic [2:0]            bit_cnt_d, bit_cnt_q;
  logic [7:0]            shift_d, shift_q;
  logic [7:0]            data_d, data_q;
  logic                  wr_d, wr_q;
  logic                  ferr_d, ferr_q;
  logic                  tick;

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    ferr_d    = 1'b0;

    // Free-running countdown in the timed states; a state action that fires
    // on tick overrides this with a reload.
    if ((state_q == StStart || state_q == StData || state_q == StStop) && !tick) begin
      cnt_d = cnt_q - CntOne;
    end

    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end
      StStart: begin
        if (tick) begin
          if (!rx_s) begin
            state_d   = StData;
            cnt_d     = BaudLoad;
            bit_cnt_d = 3'd0;
          end else begin
            // Line came back high before mid-start-bit: treat as a glitch.
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (tick) begin
          shift_d   = {rx_s, shift_q[7:1]};
          cnt_d     = BaudLoad;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (tick) begin
          data_d  = shift_q;
          wr_d    = 1'b1;
          ferr_d  = !rx_s;
          // Leaving at mid-stop-bit lets a following start bit be caught
          // even with no idle time between frames.
          state_d = rx_s ? StIdle : StBreak;
        end
      end
      StBreak: begin
        // Held-low line: wait for idle so it cannot re-trigger a frame.
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      wr_q      <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign o_wr        = wr_q;
  assign o_data      = data_q;
  assign o_frame_err = ferr_q;

endmodule
